// File: rtl/rgb_frame_writer.sv
// rgb_frame_writer: final pipeline stage that packs 8-bit R/G/B pixels into
// 32-bit words {8'h00,R,G,B} and writes them to frame memory over a
// request/acknowledge port, through a small elastic FIFO.
// Optional feature macro: RGB_WRITER_DOUBLE_BUFFER_EN (ping-pong frame base).
module rgb_frame_writer #(
  parameter int          width     = 320,
  parameter int          height    = 240,
  parameter logic [31:0] baseAddr  = 32'h0,
  parameter int          fifoDepth = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        iValid,
  input  logic [7:0]  iR,
  input  logic [7:0]  iG,
  input  logic [7:0]  iB,
  input  logic        iDone,
  input  logic        iWrAck,
  output logic        oWrReq,
  output logic [31:0] oWrAddress,
  output logic [31:0] oWrData,
  output logic [31:0] oPixelCnt,
  output logic        oFrameDone,
  output logic        oOverflow,
  output logic        oBusy
`ifdef RGB_WRITER_DOUBLE_BUFFER_EN
  ,
  output logic        oBufSel
`endif
);

  localparam int                frameSize  = width * height;
  localparam logic [31:0]       frameSizeW = 32'(frameSize);
  localparam int                ptrW       = $clog2(fifoDepth);
  localparam int                cntW       = ptrW + 1;
  localparam logic [cntW-1:0]   depthW     = cntW'(fifoDepth);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_FLUSH
  } state_e;

  state_e            state_q, state_d;
  logic [23:0]       mem_q [fifoDepth];
  logic [23:0]       mem_d [fifoDepth];
  logic [ptrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ptrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [cntW-1:0]   count_q, count_d;
  logic [cntW-1:0]   flush_left_q, flush_left_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       pix_cnt_q, pix_cnt_d;
  logic              overflow_q, overflow_d;
  logic              push, pop, frame_end;
  logic [31:0]       next_base;
  logic [31:0]       remaining;

  // Request generation: in STREAM any queued word may go out; in FLUSH only
  // the words that still belong to the frame being closed (flush_left).
  always_comb begin
    oWrReq = 1'b0;
    case (state_q)
      ST_STREAM: oWrReq = (count_q != '0);
      ST_FLUSH:  oWrReq = (flush_left_q != '0);
      default:   oWrReq = 1'b0;
    endcase
    frame_end = (state_q == ST_FLUSH) && (flush_left_q == '0);
    pop       = oWrReq && iWrAck;
    push      = iValid && ((count_q < depthW) || pop);
  end

`ifdef RGB_WRITER_DOUBLE_BUFFER_EN
  logic buf_sel_q, buf_sel_d;

  // Buffer select flips at every frame completion; the next frame base follows it.
  always_comb begin
    buf_sel_d = buf_sel_q;
    if (frame_end) begin
      buf_sel_d = ~buf_sel_q;
    end
    next_base = buf_sel_d ? (baseAddr + frameSizeW) : baseAddr;
  end

  // Buffer select register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_sel_q <= 1'b0;
    end else begin
      buf_sel_q <= buf_sel_d;
    end
  end

  assign oBufSel = buf_sel_q;
`else
  assign next_base = baseAddr;
`endif

  // FIFO storage, pointers, address/pixel counters and sticky overflow.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    addr_d     = addr_q;
    pix_cnt_d  = pix_cnt_q;
    overflow_d = overflow_q | (iValid & ~push);
    if (push) begin
      mem_d[wr_ptr_q] = {iR, iG, iB};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      addr_d    = addr_q + 32'd1;
      pix_cnt_d = pix_cnt_q + 32'd1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    if (frame_end) begin
      addr_d    = next_base;
      pix_cnt_d = '0;
    end
  end

  // Frame state machine. On entry to FLUSH the words still owed to this
  // frame are latched, capped so the frame never exceeds frameSize words;
  // anything pushed afterwards is kept for the next frame. IDLE also leaves
  // on a non-empty FIFO so pixels queued during FLUSH are not stranded.
  always_comb begin
    state_d      = state_q;
    flush_left_d = flush_left_q;
    remaining    = frameSizeW - pix_cnt_d;
    case (state_q)
      ST_IDLE: begin
        if (iValid || (count_q != '0)) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if ((pop && (pix_cnt_q + 32'd1 == frameSizeW)) || iDone) begin
          state_d = ST_FLUSH;
          if (32'(count_d) <= remaining) begin
            flush_left_d = count_d;
          end else begin
            flush_left_d = remaining[cntW-1:0];
          end
        end
      end
      ST_FLUSH: begin
        if (pop) begin
          flush_left_d = flush_left_q - 1'b1;
        end
        if (frame_end) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops all queued words immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      flush_left_q <= '0;
      addr_q       <= baseAddr;
      pix_cnt_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      flush_left_q <= flush_left_d;
      addr_q       <= addr_d;
      pix_cnt_q    <= pix_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  assign oWrAddress = addr_q;
  assign oWrData    = (count_q != '0) ? {8'h00, mem_q[rd_ptr_q]} : 32'h0;
  assign oPixelCnt  = pix_cnt_q;
  assign oFrameDone = frame_end;
  assign oOverflow  = overflow_q;
  assign oBusy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rgb_frame_writer.sv
// tb_rgb_frame_writer: scoreboard bench for rgb_frame_writer. Expected words
// are derived from pixel order and frame boundaries and queued on issue; a
// monitor pops and compares whenever a word is acknowledged.
module tb_rgb_frame_writer;

  localparam int          W     = 4;
  localparam int          H     = 2;
  localparam int          FS    = W * H;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h100;

  logic        clk;
  logic        reset_n;
  logic        iValid;
  logic [7:0]  iR, iG, iB;
  logic        iDone;
  logic        iWrAck;
  logic        oWrReq;
  logic [31:0] oWrAddress, oWrData, oPixelCnt;
  logic        oFrameDone, oOverflow, oBusy;
`ifdef RGB_WRITER_DOUBLE_BUFFER_EN
  logic        oBufSel;
`endif

  rgb_frame_writer #(
    .width(W), .height(H), .baseAddr(BASE), .fifoDepth(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .iValid(iValid),
    .iR(iR), .iG(iG), .iB(iB), .iDone(iDone), .iWrAck(iWrAck),
    .oWrReq(oWrReq), .oWrAddress(oWrAddress), .oWrData(oWrData),
    .oPixelCnt(oPixelCnt), .oFrameDone(oFrameDone),
    .oOverflow(oOverflow), .oBusy(oBusy)
`ifdef RGB_WRITER_DOUBLE_BUFFER_EN
    , .oBufSel(oBufSel)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cnt;
    int          frame;
  } word_t;

  word_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  int    ack_mode = 0;
  int    frame_word = 0;
  int    frame_num = 0;
  int    done_count = 0;
  int    last_ack_cyc = 0;
  int    idone_cyc = 0;
  int    last_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] frameBase(input int fn);
`ifdef RGB_WRITER_DOUBLE_BUFFER_EN
    return (fn % 2 == 1) ? BASE + 32'(FS) : BASE;
`else
    return (fn >= 0) ? BASE : BASE;
`endif
  endfunction

  function automatic void closeFrame();
    frame_word = 0;
    frame_num++;
  endfunction

  // Ack driver: low, high or random, updated just after each rising edge.
  initial begin
    iWrAck = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0:       iWrAck = 1'b0;
        1:       iWrAck = 1'b1;
        default: iWrAck = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: scoreboard compare on each acknowledged word, hold-stability
  // while stalled, and frame-done pulse shape/timing.
  initial begin
    logic        prev_stall = 1'b0;
    logic        prev_done  = 1'b0;
    logic [31:0] held_addr  = '0;
    logic [31:0] held_data  = '0;
    word_t       e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (prev_stall && oWrReq) begin
          checkOutput("holdAddr", oWrAddress, held_addr);
          checkOutput("holdData", oWrData, held_data);
        end
        if (oWrReq && iWrAck) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL unexpectedWord: got addr 0x%0h data 0x%0h with no word expected", oWrAddress, oWrData);
          end else begin
            e = exp_q.pop_front();
            checkOutput("wordAddr", oWrAddress, e.addr);
            checkOutput("wordData", oWrData, e.data);
            checkOutput("wordCnt", oPixelCnt, e.cnt);
`ifdef RGB_WRITER_DOUBLE_BUFFER_EN
            checkOutput("wordBufSel", oBufSel, 64'(e.frame % 2));
`endif
            last_cnt = int'(e.cnt);
          end
          last_ack_cyc = cyc;
        end
        if (oFrameDone) begin
          checkOutput("donePulseWidth", prev_done, 0);
          checkOutput("doneBusy", oBusy, 1);
          checkOutput("doneTiming", cyc, ((last_ack_cyc > idone_cyc) ? last_ack_cyc : idone_cyc) + 1);
          checkOutput("donePixelCnt", oPixelCnt, last_cnt + 1);
          done_count++;
        end
        prev_done  = oFrameDone;
        prev_stall = oWrReq && !iWrAck;
        held_addr  = oWrAddress;
        held_data  = oWrData;
      end
    end
  end

  // One pixel strobe; the model accepts it while fewer than DEPTH words wait.
  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    word_t w;
    iValid = 1'b1;
    iR = r;
    iG = g;
    iB = b;
    if (exp_q.size() < DEPTH) begin
      w.addr  = frameBase(frame_num) + 32'(frame_word);
      w.data  = {8'h00, r, g, b};
      w.cnt   = 32'(frame_word);
      w.frame = frame_num;
      exp_q.push_back(w);
      frame_word++;
      if (frame_word == FS) closeFrame();
    end
    @(posedge clk);
    #1;
    iValid = 1'b0;
  endtask

  task automatic sendDone();
    iDone = 1'b1;
    idone_cyc = cyc;
    if (frame_word != 0) closeFrame();
    @(posedge clk);
    #1;
    iDone = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitFrameDone();
    int n = 0;
    while (done_count < frame_num && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("frameDoneSeen", done_count, frame_num);
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("drained", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "Busy"}, oBusy, 0);
    checkOutput({tag, "PixelCnt"}, oPixelCnt, 0);
    checkOutput({tag, "Addr"}, oWrAddress, frameBase(frame_num));
`ifdef RGB_WRITER_DOUBLE_BUFFER_EN
    checkOutput({tag, "BufSel"}, oBufSel, 64'(frame_num % 2));
`endif
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "WrReq"}, oWrReq, 0);
    checkOutput({tag, "Addr"}, oWrAddress, BASE);
    checkOutput({tag, "Data"}, oWrData, 0);
    checkOutput({tag, "PixelCnt"}, oPixelCnt, 0);
    checkOutput({tag, "FrameDone"}, oFrameDone, 0);
    checkOutput({tag, "Overflow"}, oOverflow, 0);
    checkOutput({tag, "Busy"}, oBusy, 0);
`ifdef RGB_WRITER_DOUBLE_BUFFER_EN
    checkOutput({tag, "BufSel"}, oBufSel, 0);
`endif
  endtask

  initial begin
    logic any_req;
    int   n;
    reset_n = 1'b0;
    iValid  = 1'b0;
    iDone   = 1'b0;
    iR = '0;
    iG = '0;
    iB = '0;
    idleCycles(3);
    checkResetValues("rst");
    reset_n = 1'b1;
    idleCycles(2);

    // Full frame with ack tied high.
    ack_mode = 1;
    idleCycles(2);
    for (int k = 0; k < FS; k++) applyStimulus(8'(k), 8'(k + 1), 8'(k + 2));
    waitFrameDone();
    checkIdle("full");

    // Back-pressure: 12-pixel burst with ack low for 10 cycles in the middle.
    for (int k = 0; k < 3; k++) applyStimulus(8'(8'h20 + k), 8'(8'h40 + k), 8'(8'h60 + k));
    ack_mode = 0;
    for (int k = 3; k < 12; k++) applyStimulus(8'(8'h20 + k), 8'(8'h40 + k), 8'(8'h60 + k));
    idleCycles(1);
    ack_mode = 1;
    waitFrameDone();
    waitDrain();
    sendDone();
    waitFrameDone();
    checkIdle("bp");
    checkOutput("bpNoOverflow", oOverflow, 0);

    // Short frame: iDone after 5 pixels, random ack.
    ack_mode = 2;
    for (int k = 0; k < 5; k++) applyStimulus(8'($urandom), 8'($urandom), 8'($urandom));
    sendDone();
    waitFrameDone();
    checkIdle("short");

    // Overflow: ack low, 18 pixels back to back; the last two are dropped.
    ack_mode = 0;
    idleCycles(2);
    for (int k = 0; k < 18; k++) applyStimulus(8'(k), 8'(8'hA0 + k), 8'(8'hF0 - k));
    idleCycles(1);
    checkOutput("overflowSet", oOverflow, 1);
    ack_mode = 1;
    waitFrameDone();
    waitFrameDone();
    checkOutput("overflowSticky", oOverflow, 1);
    checkIdle("ovf");

    // Randomized frames: random length, gaps and ack pattern.
    ack_mode = 2;
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, FS);
      for (int k = 0; k < n; k++) begin
        applyStimulus(8'($urandom), 8'($urandom), 8'($urandom));
        idleCycles($urandom_range(0, 2));
      end
      if (n < FS) sendDone();
      waitFrameDone();
    end
    checkIdle("rand");

    // Reset mid-stream with 5 words queued.
    ack_mode = 0;
    idleCycles(2);
    for (int k = 0; k < 5; k++) applyStimulus(8'(k), 8'(k), 8'(k));
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checkResetValues("midRst");
    exp_q.delete();
    frame_word = 0;
    frame_num  = 0;
    done_count = 0;
    idleCycles(3);
    reset_n  = 1'b1;
    ack_mode = 1;
    any_req  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      idleCycles(1);
      any_req = any_req | oWrReq;
    end
    checkOutput("noReqAfterReset", any_req, 0);
    for (int k = 0; k < 3; k++) applyStimulus(8'(8'h11 * k), 8'h5A, 8'hC3);
    sendDone();
    waitFrameDone();
    checkIdle("postRst");

    checkOutput("leftoverWords", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
